// File: rtl/mem_cycle_ctl_pkg.sv
// Shared bus definitions for the memory cycle sequencer: state encoding,
// register-unit read-select source codes and strobe polarity.
package mem_cycle_ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ASEL  = 3'd1,
    ST_STRB  = 3'd2,
    ST_WAITR = 3'd3,
    ST_WB    = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

  // Register-unit read-select codes
  localparam logic [2:0] RSEL_ZERO = 3'd0;
  localparam logic [2:0] RSEL_R1   = 3'd1;
  localparam logic [2:0] RSEL_R2   = 3'd2;
  localparam logic [2:0] RSEL_R3   = 3'd3;
  localparam logic [2:0] RSEL_P2   = 3'd4;
  localparam logic [2:0] RSEL_P1   = 3'd5;
  localparam logic [2:0] RSEL_M2   = 3'd6;
  localparam logic [2:0] RSEL_M1   = 3'd7;

  // All strobes and enables on both buses are negative true
  localparam logic STRB_ON  = 1'b0;
  localparam logic STRB_OFF = 1'b1;

  function automatic logic is_strobe_state(input state_t s);
    return (s == ST_STRB) || (s == ST_WAITR);
  endfunction

endpackage

// File: rtl/mem_cycle_ctl_bus_wait_timer.sv
// Wait-state down-counter plus optional WAITR timeout counter (MEM_TIMEOUT_EN).
// Both counters reload on an accepted request and saturate at zero.
module bus_wait_timer #(
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 15
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_load,
  input  logic i_ws_en,
  input  logic i_to_en,
  output logic o_ws_done,
  output logic o_to_expired
);

  localparam logic [2:0] WS_LOAD = 3'(WAIT_STATES - 1);
  localparam logic [3:0] TO_LOAD = 4'(TIMEOUT - 1);

  logic [2:0] r_ws_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ws_cnt <= '0;
    end else if (i_load) begin
      r_ws_cnt <= WS_LOAD;
    end else if (i_ws_en && (r_ws_cnt != 3'd0)) begin
      r_ws_cnt <= r_ws_cnt - 3'd1;
    end
  end

  assign o_ws_done = (r_ws_cnt == 3'd0);

`ifdef MEM_TIMEOUT_EN
  logic [3:0] r_to_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_to_cnt <= '0;
    end else if (i_load) begin
      r_to_cnt <= TO_LOAD;
    end else if (i_to_en && (r_to_cnt != 4'd0)) begin
      r_to_cnt <= r_to_cnt - 4'd1;
    end
  end

  // Expires on the last of TIMEOUT consecutive WAITR cycles
  assign o_to_expired = i_to_en && (r_to_cnt == 4'd0);
`else
  logic w_unused_to;
  assign w_unused_to  = i_to_en ^ TO_LOAD[0];
  assign o_to_expired = 1'b0;
`endif

endmodule

// File: rtl/mem_cycle_ctl.sv
// Bus-cycle sequencer: address select, strobed memory read/write with wait
// states, register write-back. Optional WAITR timeout under MEM_TIMEOUT_EN.
module mem_cycle_ctl
  import mem_cycle_ctl_pkg::*;
#(
  parameter int AW          = 16,
  parameter int DW          = 16,
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 15
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_req,
  input  logic          i_rw,
  input  logic [2:0]    i_src,
  input  logic [1:0]    i_dst,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_addr,
  output logic [2:0]    o_rsel,
  output logic          o_oe,
  output logic [DW-1:0] o_data,
  output logic          o_wren,
  output logic [1:0]    o_wsel,
  output logic [AW-1:0] o_maddr,
  output logic [DW-1:0] o_mdout,
  output logic          o_mdoe_n,
  input  logic [DW-1:0] i_mdin,
  input  logic          i_mrdy,
  output logic          o_mrd_n,
  output logic          o_mwr_n,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  state_t          r_state, w_next;
  logic            r_rw;
  logic [1:0]      r_dst;
  logic [DW-1:0]   r_rdata;
  logic            r_err;
  logic [2:0]      r_rsel;
  logic            r_oe, r_wren, r_mrd_n, r_mwr_n, r_mdoe_n, r_busy, r_done;
  logic [1:0]      r_wsel;
  logic [AW-1:0]   r_maddr;
  logic [DW-1:0]   r_mdout;

  logic            w_accept, w_capture, w_timeout, w_ws_done, w_to_expired, w_strb_next;

  assign w_accept = (r_state == ST_IDLE) && i_req;

  bus_wait_timer #(
    .WAIT_STATES (WAIT_STATES),
    .TIMEOUT     (TIMEOUT)
  ) u_timer (
    .CLK          (CLK),
    .RST          (RST),
    .i_load       (w_accept),
    .i_ws_en      (r_state == ST_STRB),
    .i_to_en      (r_state == ST_WAITR),
    .o_ws_done    (w_ws_done),
    .o_to_expired (w_to_expired)
  );

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE:  if (i_req) w_next = ST_ASEL;
      ST_ASEL:  w_next = ST_STRB;
      ST_STRB, ST_WAITR: begin
        if ((r_state == ST_WAITR) || w_ws_done) begin
          if (i_mrdy) begin
            w_capture = r_rw;
            w_next    = (r_rw && (r_dst != 2'd0)) ? ST_WB : ST_FIN;
          end else if (w_to_expired) begin
            w_timeout = 1'b1;
            w_next    = ST_FIN;
          end else begin
            w_next = ST_WAITR;
          end
        end
      end
      ST_WB:    w_next = ST_FIN;
      ST_FIN:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  assign w_strb_next = is_strobe_state(w_next);

  // Outputs are registered from the next state so every strobe is glitch-free
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_rw     <= 1'b0;
      r_dst    <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_rsel   <= RSEL_ZERO;
      r_oe     <= STRB_OFF;
      r_wren   <= STRB_OFF;
      r_wsel   <= '0;
      r_mrd_n  <= STRB_OFF;
      r_mwr_n  <= STRB_OFF;
      r_mdoe_n <= STRB_OFF;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_maddr  <= '0;
      r_mdout  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_rw  <= i_rw;
        r_dst <= i_dst;
        if (!i_rw) r_mdout <= i_wdata;
      end
      if (r_state == ST_ASEL) r_maddr <= i_addr;
      if (w_capture) r_rdata <= i_mdin;

      if (w_accept)       r_err <= 1'b0;
      else if (w_timeout) r_err <= 1'b1;

      r_rsel   <= w_accept ? i_src : RSEL_ZERO;
      r_oe     <= w_accept ? STRB_ON : STRB_OFF;
      r_mrd_n  <= (w_strb_next && r_rw)  ? STRB_ON : STRB_OFF;
      r_mwr_n  <= (w_strb_next && !r_rw) ? STRB_ON : STRB_OFF;
      // Data drive held through FIN after a write for hold time
      r_mdoe_n <= (!r_rw && (w_strb_next || (w_next == ST_FIN))) ? STRB_ON : STRB_OFF;
      r_wren   <= (w_next == ST_WB) ? STRB_ON : STRB_OFF;
      r_wsel   <= (w_next == ST_WB) ? r_dst : 2'd0;
      r_busy   <= (w_next != ST_IDLE);
      r_done   <= (w_next == ST_FIN);
    end
  end

  assign o_data   = (r_state == ST_WB) ? r_rdata : {DW{1'bz}};
  assign o_rsel   = r_rsel;
  assign o_oe     = r_oe;
  assign o_wren   = r_wren;
  assign o_wsel   = r_wsel;
  assign o_maddr  = r_maddr;
  assign o_mdout  = r_mdout;
  assign o_mdoe_n = r_mdoe_n;
  assign o_mrd_n  = r_mrd_n;
  assign o_mwr_n  = r_mwr_n;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_err    = r_err;

endmodule

// File: tb/tb_mem_cycle_ctl.sv
// Self-checking bench for mem_cycle_ctl: directed table, randomized cycles
// against a cycle-timeline model, reset abort and (MEM_TIMEOUT_EN) timeout.
module tb_mem_cycle_ctl;

  localparam int WS = 1;
  localparam int TO = 15;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req = 1'b0, rw = 1'b0, mrdy = 1'b0;
  logic [2:0]  src = '0;
  logic [1:0]  dst = '0;
  logic [15:0] wdata = '0, mdin = '0, cur_addr = '0;
  logic [15:0] addr;
  logic [2:0]  rsel;
  logic        oe, wren, mdoe_n, mrd_n, mwr_n, busy, done, err;
  logic [1:0]  wsel;
  logic [15:0] maddr, mdout;
  wire  [15:0] data;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  // Register unit only drives a meaningful address while OE is asserted
  assign addr = oe ? 16'hDEAD : cur_addr;

  mem_cycle_ctl #(.AW(16), .DW(16), .WAIT_STATES(WS), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .i_req(req), .i_rw(rw), .i_src(src), .i_dst(dst),
    .i_wdata(wdata), .i_addr(addr), .o_rsel(rsel), .o_oe(oe), .o_data(data),
    .o_wren(wren), .o_wsel(wsel), .o_maddr(maddr), .o_mdout(mdout),
    .o_mdoe_n(mdoe_n), .i_mdin(mdin), .i_mrdy(mrdy), .o_mrd_n(mrd_n),
    .o_mwr_n(mwr_n), .o_busy(busy), .o_done(done), .o_err(err)
  );

  typedef struct {
    logic        rw;
    logic [2:0]  src;
    logic [1:0]  dst;
    logic [15:0] wdata;
    logic [15:0] addr;
    logic [15:0] mdin;
    int          k;
    bit          hold;
    int          exp_done;
    int          exp_wren;
    int          exp_strb;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One full cycle; expected behaviour comes from a timeline: ASEL, WS+k strobe
  // cycles (MRDY only on the last), optional WB, FIN.
  task automatic run_txn(input vec_t v, input bit directed);
    int n_strb, wb, len, s, done_at, wren_cnt, strb_cnt;
    bit in_strb;
    logic [6:0] exp_ctl, act_ctl;
    n_strb = WS + v.k;
    wb     = (v.rw && v.dst != 2'd0) ? 1 : 0;
    len    = 1 + n_strb + wb + 1;
    step();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    req = 1'b1; rw = v.rw; src = v.src; dst = v.dst; wdata = v.wdata;
    cur_addr = v.addr; mrdy = 1'($urandom); mdin = 16'($urandom);
    done_at = 0; wren_cnt = 0; strb_cnt = 0;
    for (int c = 1; c <= len; c++) begin
      step();
      req = v.hold ? 1'b1 : 1'($urandom_range(0, 1));
      s = c - 1;
      if (s >= WS && s < n_strb) begin
        mrdy = 1'b0; mdin = 16'($urandom);
      end else if (s == n_strb) begin
        mrdy = 1'b1; mdin = v.mdin;
      end else begin
        mrdy = 1'($urandom); mdin = 16'($urandom);
      end
      in_strb = (c >= 2) && (c <= 1 + n_strb);
      exp_ctl = {1'b1, (c == len), (c != 1),
                 !(in_strb && v.rw), !(in_strb && !v.rw),
                 !(!v.rw && (in_strb || c == len)),
                 !(wb == 1 && c == len - 1)};
      act_ctl = {busy, done, oe, mrd_n, mwr_n, mdoe_n, wren};
      chk($sformatf("ctl_c%0d", c), {25'd0, act_ctl}, {25'd0, exp_ctl});
      if (c == 1) chk("rsel", {29'd0, rsel}, {29'd0, v.src});
      if (c == 2) chk("maddr", {16'd0, maddr}, {16'd0, v.addr});
      if (c == 2 && !v.rw) chk("mdout", {16'd0, mdout}, {16'd0, v.wdata});
      if (wb == 1 && c == len - 1) begin
        chk("wsel", {30'd0, wsel}, {30'd0, v.dst});
        chk("data", {16'd0, data}, {16'd0, v.mdin});
      end
      if (c == len) chk("err_clr", {31'd0, err}, 32'd0);
      if (done && done_at == 0) done_at = c;
      if (!wren) wren_cnt++;
      if (!mrd_n || !mwr_n) strb_cnt++;
    end
    if (directed) begin
      chk("done_cycle", done_at, v.exp_done);
      chk("wren_cycles", wren_cnt, v.exp_wren);
      chk("strobe_cycles", strb_cnt, v.exp_strb);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      req = 1'b0;
      chk("gap_busy", {30'd0, busy, done}, 32'd0);
    end
  endtask

  vec_t tbl[6];
  vec_t rv;
  int   to_done, to_wren;

  initial begin
    //        rw    src   dst   wdata      addr       mdin       k  hold done wren strb
    tbl[0] = '{1'b1, 3'd1, 2'd2, 16'h0000, 16'h1234, 16'hBEEF, 0, 1'b0, 4, 1, 1};
    tbl[1] = '{1'b0, 3'd4, 2'd0, 16'h55AA, 16'h0002, 16'h0000, 0, 1'b0, 3, 0, 1};
    tbl[2] = '{1'b1, 3'd2, 2'd3, 16'h0000, 16'h0ABC, 16'h1357, 5, 1'b0, 9, 1, 6};
    tbl[3] = '{1'b1, 3'd7, 2'd0, 16'h0000, 16'hFFFF, 16'h2468, 0, 1'b1, 3, 0, 1};
    tbl[4] = '{1'b1, 3'd5, 2'd0, 16'h0000, 16'h0001, 16'h9999, 0, 1'b1, 3, 0, 1};
    tbl[5] = '{1'b0, 3'd6, 2'd1, 16'hA5A5, 16'hFFFE, 16'h0000, 2, 1'b1, 5, 0, 3};

    repeat (2) step();
    chk("rst_ctl", {22'd0, busy, done, err, oe, wren, mrd_n, mwr_n, mdoe_n, rsel},
        {22'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0});
    chk("rst_addr", {maddr, mdout}, 32'd0);
    chk("rst_wsel", {30'd0, wsel}, 32'd0);
    RST = 1'b0;

    foreach (tbl[i]) run_txn(tbl[i], 1'b1);
    idle_cycles(2);

    // Reset during STRB aborts the cycle
    step();
    req = 1'b1; rw = 1'b1; src = 3'd3; dst = 2'd1; cur_addr = 16'h4444; mrdy = 1'b0;
    step();
    req = 1'b0;
    step();
    chk("abort_strb", {31'd0, mrd_n}, 32'd0);
    RST = 1'b1;
    step();
    chk("abort_state", {26'd0, mrd_n, busy, done, wren, oe, err}, {26'd0, 6'b100110});
    chk("abort_maddr", {16'd0, maddr}, 32'd0);
    RST = 1'b0;
    mrdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_after", {29'd0, busy, done, wren}, {29'd0, 3'b001});
    end

`ifdef MEM_TIMEOUT_EN
    step();
    req = 1'b1; rw = 1'b1; dst = 2'd1; src = 3'd1; cur_addr = 16'h0100; mrdy = 1'b0;
    to_done = 0; to_wren = 0;
    for (int c = 1; c <= 22; c++) begin
      step();
      req = 1'b0;
      if (done) begin
        to_done = c;
        chk("to_err_set", {31'd0, err}, 32'd1);
      end
      if (!wren) to_wren++;
    end
    chk("to_done_cycle", to_done, 1 + WS + TO + 1);
    chk("to_no_wren", to_wren, 0);
    chk("to_err_sticky", {31'd0, err}, 32'd1);
    req = 1'b1; mrdy = 1'b1;
    step();
    req = 1'b0;
    chk("to_err_cleared", {31'd0, err}, 32'd0);
    repeat (5) step();
`endif

    for (int n = 0; n < 40; n++) begin
      rv.rw    = 1'($urandom);
      rv.src   = 3'($urandom);
      rv.dst   = 2'($urandom);
      rv.wdata = 16'($urandom);
      rv.addr  = 16'($urandom);
      rv.mdin  = 16'($urandom);
      rv.k     = $urandom_range(0, 6);
      rv.hold  = 1'($urandom);
      rv.exp_done = 0; rv.exp_wren = 0; rv.exp_strb = 0;
      run_txn(rv, 1'b0);
      if ($urandom_range(0, 3) == 0) idle_cycles(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
